// File: rtl/countdown_timer.sv
// BCD MM:SS countdown timer with IDLE/RUN/PAUSE/DONE control and a one-cycle expire pulse.
// Digits and flags are registered; control inputs are single-cycle pulses.
module countdown_timer #(
    parameter int unsigned MIN_TENS_MAX = 9
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tick,
    input  logic       start,
    input  logic       stop,
    input  logic       clear,
    input  logic       load,
    input  logic [3:0] ld_m1,
    input  logic [3:0] ld_m0,
    input  logic [3:0] ld_s1,
    input  logic [3:0] ld_s0,
    output logic [3:0] m1,
    output logic [3:0] m0,
    output logic [3:0] s1,
    output logic [3:0] s0,
    output logic       running,
    output logic       done,
    output logic       expire
);

    localparam logic [3:0] M1Max = 4'(MIN_TENS_MAX);

    typedef enum logic [1:0] {StIdle, StRun, StPause, StDone} state_e;

    state_e     state_q, state_d;
    logic [3:0] m1_q, m1_d, m0_q, m0_d, s1_q, s1_d, s0_q, s0_d;
    logic       expire_q, expire_d;
    logic       is_zero, is_one;

    function automatic logic [3:0] clamp(input logic [3:0] v, input logic [3:0] lim);
        return (v > lim) ? lim : v;
    endfunction

    assign is_zero = (m1_q == 4'd0) && (m0_q == 4'd0) && (s1_q == 4'd0) && (s0_q == 4'd0);
    assign is_one  = (m1_q == 4'd0) && (m0_q == 4'd0) && (s1_q == 4'd0) && (s0_q == 4'd1);

    always_comb begin
        state_d  = state_q;
        m1_d     = m1_q;
        m0_d     = m0_q;
        s1_d     = s1_q;
        s0_d     = s0_q;
        expire_d = 1'b0;
        if (clear) begin
            m1_d    = 4'd0;
            m0_d    = 4'd0;
            s1_d    = 4'd0;
            s0_d    = 4'd0;
            state_d = StIdle;
        end else if (load && (state_q != StRun)) begin
            m1_d    = clamp(ld_m1, M1Max);
            m0_d    = clamp(ld_m0, 4'd9);
            s1_d    = clamp(ld_s1, 4'd5);
            s0_d    = clamp(ld_s0, 4'd9);
            state_d = StIdle;
        end else begin
            case (state_q)
                // stop outranks start, so a coincident pair leaves the timer parked
                StIdle, StPause: begin
                    if (!stop && start && !is_zero) state_d = StRun;
                end
                StRun: begin
                    if (tick) begin
                        if (s0_q != 4'd0) begin
                            s0_d = s0_q - 4'd1;
                        end else begin
                            s0_d = 4'd9;
                            if (s1_q != 4'd0) begin
                                s1_d = s1_q - 4'd1;
                            end else begin
                                s1_d = 4'd5;
                                if (m0_q != 4'd0) begin
                                    m0_d = m0_q - 4'd1;
                                end else begin
                                    m0_d = 4'd9;
                                    m1_d = m1_q - 4'd1;
                                end
                            end
                        end
                    end
                    // Reaching 00:00 wins over a coincident stop
                    if (tick && is_one) begin
                        state_d  = StDone;
                        expire_d = 1'b1;
                    end else if (stop) begin
                        state_d = StPause;
                    end
                end
                StDone: ;
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= StIdle;
            m1_q     <= 4'd0;
            m0_q     <= 4'd0;
            s1_q     <= 4'd0;
            s0_q     <= 4'd0;
            expire_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            m1_q     <= m1_d;
            m0_q     <= m0_d;
            s1_q     <= s1_d;
            s0_q     <= s0_d;
            expire_q <= expire_d;
        end
    end

    assign m1      = m1_q;
    assign m0      = m0_q;
    assign s1      = s1_q;
    assign s0      = s0_q;
    assign running = (state_q == StRun);
    assign done    = (state_q == StDone);
    assign expire  = expire_q;

endmodule

// File: tb/tb_countdown_timer.sv
// Scoreboard bench for countdown_timer: a seconds-based reference model predicts each cycle's
// outputs into a queue; a monitor pops and compares them on the falling edge.
module tb_countdown_timer;

    localparam int MaxM1 = 9;
    localparam int Idle = 0, Run = 1, Pause = 2, Done = 3;

    logic       clk = 1'b0, rst = 1'b0;
    logic       tick = 1'b0, start = 1'b0, stop = 1'b0, clear = 1'b0, load = 1'b0;
    logic [3:0] ld_m1 = '0, ld_m0 = '0, ld_s1 = '0, ld_s0 = '0;
    logic [3:0] m1, m0, s1, s0;
    logic       running, done, expire;

    countdown_timer #(.MIN_TENS_MAX(MaxM1)) dut (
        .clk(clk), .rst(rst), .tick(tick), .start(start), .stop(stop), .clear(clear),
        .load(load), .ld_m1(ld_m1), .ld_m0(ld_m0), .ld_s1(ld_s1), .ld_s0(ld_s0),
        .m1(m1), .m0(m0), .s1(s1), .s0(s0),
        .running(running), .done(done), .expire(expire)
    );

    always #5 clk = ~clk;

    int n_tests = 0, n_fail = 0;
    int ms = Idle;
    int secs = 0;
    bit mexp = 1'b0;
    logic [18:0] exp_q[$];

    function automatic logic [18:0] model_out();
        int m, s;
        m = secs / 60;
        s = secs % 60;
        return {4'(m / 10), 4'(m % 10), 4'(s / 10), 4'(s % 10),
                ms == Run, ms == Done, mexp};
    endfunction

    function automatic string fmt(input logic [18:0] v);
        return $sformatf("%0h%0h:%0h%0h run=%0b done=%0b expire=%0b",
                         v[18:15], v[14:11], v[10:7], v[6:3], v[2], v[1], v[0]);
    endfunction

    function automatic int lim(input int v, input int l);
        return (v > l) ? l : v;
    endfunction

    // Reference behaviour on remaining time in whole seconds
    task automatic model_step(input bit t, st, sp, cl, ld, input int a, b, c, d);
        mexp = 1'b0;
        if (cl) begin
            secs = 0;
            ms   = Idle;
        end else if (ld && ms != Run) begin
            secs = (lim(a, MaxM1) * 10 + lim(b, 9)) * 60 + lim(c, 5) * 10 + lim(d, 9);
            ms   = Idle;
        end else begin
            case (ms)
                Idle, Pause: if (!sp && st && secs != 0) ms = Run;
                Run: begin
                    if (t) secs = secs - 1;
                    if (t && secs == 0) begin
                        ms   = Done;
                        mexp = 1'b1;
                    end else if (sp) begin
                        ms = Pause;
                    end
                end
                default: ;
            endcase
        end
    endtask

    task automatic step(input bit t, st, sp, cl, ld,
                        input int a = 0, input int b = 0, input int c = 0, input int d = 0);
        @(negedge clk);
        #1;
        tick  = t;
        start = st;
        stop  = sp;
        clear = cl;
        load  = ld;
        ld_m1 = 4'(a);
        ld_m0 = 4'(b);
        ld_s1 = 4'(c);
        ld_s0 = 4'(d);
        model_step(t, st, sp, cl, ld, a, b, c, d);
        exp_q.push_back(model_out());
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) step(1, 0, 0, 0, 0);
    endtask

    task automatic async_reset();
        logic [18:0] act;
        @(negedge clk);
        #1;
        rst   = 1'b0;
        tick  = 1'b0;
        start = 1'b0;
        stop  = 1'b0;
        clear = 1'b0;
        load  = 1'b0;
        #1;
        act = {m1, m0, s1, s0, running, done, expire};
        n_tests++;
        if (act !== 19'd0) begin
            n_fail++;
            $display("FAIL async_reset: got %s want %s", fmt(act), fmt(19'd0));
        end
        ms   = Idle;
        secs = 0;
        mexp = 1'b0;
        exp_q.push_back(model_out());
        @(negedge clk);
        #1;
        rst = 1'b1;
        exp_q.push_back(model_out());
    endtask

    initial begin : monitor
        logic [18:0] e, a;
        forever begin
            @(negedge clk);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                a = {m1, m0, s1, s0, running, done, expire};
                n_tests++;
                if (a !== e) begin
                    n_fail++;
                    $display("FAIL outputs @%0t: got %s want %s", $time, fmt(a), fmt(e));
                end
            end
        end
    end

    initial begin : driver
        bit t, st, sp, cl, ld;
        int a, b, c, d;
        repeat (2) begin
            @(negedge clk);
            #1;
            exp_q.push_back(model_out());
        end
        @(negedge clk);
        #1;
        rst = 1'b1;
        exp_q.push_back(model_out());

        // 01:00 down to 00:00 with expire after the 60th tick; start ignored in DONE
        step(0, 0, 0, 0, 1, 0, 1, 0, 0);
        step(0, 1, 0, 0, 0);
        ticks(60);
        step(0, 0, 0, 0, 0);
        step(0, 1, 0, 0, 0);
        ticks(3);

        // 10:00 borrows across every digit
        step(0, 0, 0, 0, 1, 1, 0, 0, 0);
        step(0, 1, 0, 0, 0);
        ticks(600);
        step(0, 0, 0, 0, 0);

        // pause holds digits against ticks, then resumes
        step(0, 0, 0, 0, 1, 0, 0, 3, 0);
        step(0, 1, 0, 0, 0);
        ticks(5);
        step(0, 0, 1, 0, 0);
        ticks(10);
        step(0, 1, 0, 0, 0);
        ticks(1);

        // clamped load, then start at 00:00 ignored
        step(0, 0, 0, 0, 1, 7, 12, 8, 15);
        step(0, 0, 0, 0, 0);
        step(0, 0, 0, 1, 0);
        step(0, 1, 0, 0, 0);
        step(0, 0, 0, 0, 1, 15, 15, 15, 15);
        step(0, 1, 1, 0, 0);

        // tick+stop coincident, load ignored in RUN, load from PAUSE
        step(0, 0, 0, 0, 1, 0, 5, 0, 0);
        step(0, 1, 0, 0, 0);
        step(1, 0, 1, 0, 0);
        step(0, 1, 0, 0, 0);
        step(1, 0, 0, 0, 1, 1, 2, 3, 4);
        step(0, 0, 1, 0, 0);
        step(0, 0, 0, 0, 1, 0, 0, 0, 1);
        step(0, 1, 0, 0, 0);
        step(1, 0, 1, 0, 0);
        step(0, 0, 0, 0, 0);

        // async reset mid-run
        step(0, 0, 0, 0, 1, 2, 0, 0, 0);
        step(0, 1, 0, 0, 0);
        ticks(3);
        async_reset();
        step(0, 1, 0, 0, 0);

        for (int i = 0; i < 4000; i++) begin
            t  = ($urandom % 3) == 0;
            st = ($urandom % 8) == 0;
            sp = ($urandom % 16) == 0;
            cl = ($urandom % 80) == 0;
            ld = ($urandom % 20) == 0;
            if ($urandom % 2 == 0) begin
                a = 0;
                b = 0;
                c = 0;
                d = $urandom % 16;
            end else begin
                a = $urandom % 16;
                b = $urandom % 16;
                c = $urandom % 16;
                d = $urandom % 16;
            end
            step(t, st, sp, cl, ld, a, b, c, d);
            if (i % 1000 == 999) async_reset();
        end

        step(0, 0, 0, 0, 0);
        for (int k = 0; k < 20 && exp_q.size() != 0; k++) @(posedge clk);
        #1;
        n_tests++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: got %0d pending want 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
